bp_update_queue: RTL and testbench

Commit-side buffer that sits directly upstream of the branch predictor's update port. It accepts up to COMMIT_WIDTH retired control-flow records per cycle from the commit stage and compacts the sparse valid slots in program order. It then drains exactly one record per cycle into the predictor's single-ported update interface (update_valid/pc/is_cond/taken/target/is_call/is_ret). Ordering is strict, because the predictor's RAS push/pop sequence depends on it.

---
 rtl/bp_update_queue_pkg.sv | 22 ++
 rtl/bp_update_queue_if.sv | 38 +++
 rtl/bp_update_compact.sv | 22 ++
 rtl/bp_update_queue.sv | 129 ++++++++++++
 tb/tb_bp_update_queue.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_update_queue_pkg.sv
// Shared frontend types for the commit-to-predictor update path.
// Holds the global config type and the predictor update record.
package bp_update_queue_pkg;

    typedef struct packed {
        int unsigned PLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{PLEN: 32};

    // Record layout at the default physical address width; the queue builds a
    // field-compatible record sized from its own Cfg.PLEN.
    typedef struct packed {
        logic [EmptyCfg.PLEN-1:0] pc;
        logic [EmptyCfg.PLEN-1:0] target;
        logic                     is_cond;
        logic                     taken;
        logic                     is_call;
        logic                     is_ret;
    } bp_update_t;

endpackage

// File: rtl/bp_update_queue_if.sv
// Commit-group input and predictor-update output bundle of bp_update_queue.
// master drives commit records, slave is the queue itself.
interface bp_update_queue_if #(
    parameter int unsigned COMMIT_WIDTH = 4,
    parameter int unsigned PLEN         = 32,
    parameter int unsigned CNT_W        = 4
);
    logic [COMMIT_WIDTH-1:0]           in_valid_i;
    logic [COMMIT_WIDTH-1:0][PLEN-1:0] in_pc_i;
    logic [COMMIT_WIDTH-1:0][PLEN-1:0] in_target_i;
    logic [COMMIT_WIDTH-1:0]           in_is_cond_i;
    logic [COMMIT_WIDTH-1:0]           in_taken_i;
    logic [COMMIT_WIDTH-1:0]           in_is_call_i;
    logic [COMMIT_WIDTH-1:0]           in_is_ret_i;
    logic                              in_ready_o;
    logic                              update_valid_o;
    logic [PLEN-1:0]                   update_pc_o;
    logic [PLEN-1:0]                   update_target_o;
    logic                              update_is_cond_o;
    logic                              update_taken_o;
    logic                              update_is_call_o;
    logic                              update_is_ret_o;
    logic [CNT_W-1:0]                  count_o;

    modport master (
        output in_valid_i, in_pc_i, in_target_i, in_is_cond_i, in_taken_i, in_is_call_i,
               in_is_ret_i,
        input  in_ready_o, update_valid_o, update_pc_o, update_target_o, update_is_cond_o,
               update_taken_o, update_is_call_o, update_is_ret_o, count_o
    );

    modport slave (
        input  in_valid_i, in_pc_i, in_target_i, in_is_cond_i, in_taken_i, in_is_call_i,
               in_is_ret_i,
        output in_ready_o, update_valid_o, update_pc_o, update_target_o, update_is_cond_o,
               update_taken_o, update_is_call_o, update_is_ret_o, count_o
    );
endinterface

// File: rtl/bp_update_compact.sv
// Commit-slot compactor: exclusive prefix popcount of the valid mask gives each
// slot its write offset from the tail; the full popcount is the push count.
module bp_update_compact #(
    parameter int unsigned COMMIT_WIDTH = 4,
    parameter int unsigned OFS_W        = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic [COMMIT_WIDTH-1:0]            valid_i,
    output logic [COMMIT_WIDTH-1:0][OFS_W-1:0] offset_o,
    output logic [OFS_W-1:0]                   push_cnt_o
);
    logic [OFS_W-1:0] acc;

    always_comb begin
        acc      = '0;
        offset_o = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            offset_o[k] = acc;
            acc         = acc + OFS_W'(valid_i[k]);
        end
        push_cnt_o = acc;
    end
endmodule

// File: rtl/bp_update_queue.sv
// In-order commit-to-predictor update queue: compacts sparse commit slots, drains
// one record per cycle. Define BP_UPDATE_BYPASS_EN for same-cycle empty-queue bypass.
module bp_update_queue
    import bp_update_queue_pkg::*;
#(
    parameter cfg_t        Cfg          = EmptyCfg,
    parameter int unsigned COMMIT_WIDTH = 4,
    parameter int unsigned DEPTH        = 8
) (
    input logic            clk_i,
    input logic            rst_i,
    bp_update_queue_if.slave bus
);
    localparam int unsigned PLEN = Cfg.PLEN;
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned OW   = $clog2(COMMIT_WIDTH + 1);

    typedef struct packed {
        logic [PLEN-1:0] pc;
        logic [PLEN-1:0] target;
        logic            is_cond;
        logic            taken;
        logic            is_call;
        logic            is_ret;
    } rec_t;

    rec_t                            slot [COMMIT_WIDTH];
    rec_t                            mem_q [DEPTH];
    rec_t                            out_rec;
    logic                            out_valid;
    logic [PW-1:0]                   head_q, tail_q;
    logic [CW-1:0]                   count_q, count_d;
    logic [COMMIT_WIDTH-1:0][OW-1:0] offset;
    logic [OW-1:0]                   push_cnt, push_eff;
    logic [PW-1:0]                   wr_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]         wr_en;
    logic                            in_ready, accept, pop, bypass;

    always_comb begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            slot[k] = '{pc: bus.in_pc_i[k], target: bus.in_target_i[k],
                        is_cond: bus.in_is_cond_i[k], taken: bus.in_taken_i[k],
                        is_call: bus.in_is_call_i[k], is_ret: bus.in_is_ret_i[k]};
        end
    end

    bp_update_compact #(
        .COMMIT_WIDTH(COMMIT_WIDTH),
        .OFS_W       (OW)
    ) u_compact (
        .valid_i   (bus.in_valid_i),
        .offset_o  (offset),
        .push_cnt_o(push_cnt)
    );

    // Ready is a function of registered occupancy only, so commit never sees a loop.
    assign in_ready = (count_q <= CW'(DEPTH - COMMIT_WIDTH));
    assign accept   = in_ready && (|bus.in_valid_i);
    assign pop      = (count_q != '0);

`ifdef BP_UPDATE_BYPASS_EN
    rec_t first_rec;

    always_comb begin
        first_rec = '0;
        for (int k = COMMIT_WIDTH - 1; k >= 0; k--) begin
            if (bus.in_valid_i[k]) first_rec = slot[k];
        end
    end

    assign bypass = accept && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    // A bypassed slot always has offset 0; the rest shift down by one entry.
    always_comb begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            wr_en[k]  = accept && bus.in_valid_i[k] && !(bypass && (offset[k] == '0));
            wr_idx[k] = tail_q + PW'(offset[k]) - PW'(bypass);
        end
        push_eff = push_cnt - OW'(bypass);
        count_d  = count_q + (accept ? CW'(push_eff) : '0) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (wr_en[k]) mem_q[wr_idx[k]] <= slot[k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) head_q <= head_q + PW'(1);
            if (accept) tail_q <= tail_q + PW'(push_eff);
            count_q <= count_d;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_rec   = '0;
        if (pop) begin
            out_valid = 1'b1;
            out_rec   = mem_q[head_q];
        end
`ifdef BP_UPDATE_BYPASS_EN
        else if (bypass) begin
            out_valid = 1'b1;
            out_rec   = first_rec;
        end
`endif
    end

    assign bus.in_ready_o       = in_ready;
    assign bus.update_valid_o   = out_valid;
    assign bus.update_pc_o      = out_rec.pc;
    assign bus.update_target_o  = out_rec.target;
    assign bus.update_is_cond_o = out_rec.is_cond;
    assign bus.update_taken_o   = out_rec.taken;
    assign bus.update_is_call_o = out_rec.is_call;
    assign bus.update_is_ret_o  = out_rec.is_ret;
    assign bus.count_o          = count_q;
endmodule

// File: tb/tb_bp_update_queue.sv
// Self-checking bench for bp_update_queue: directed scenarios plus random traffic
// compared against a queue-based reference model (honours BP_UPDATE_BYPASS_EN).
module tb_bp_update_queue;
    import bp_update_queue_pkg::*;

    localparam int unsigned W     = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PLEN  = 32;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef BP_UPDATE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        is_cond;
        logic        taken;
        logic        is_call;
        logic        is_ret;
    } trec_t;

    logic  clk, rst;
    int    total = 0;
    int    bad   = 0;
    trec_t mq[$];

    bp_update_queue_if #(.COMMIT_WIDTH(W), .PLEN(PLEN), .CNT_W(CNT_W)) bus ();

    bp_update_queue #(
        .Cfg         (EmptyCfg),
        .COMMIT_WIDTH(W),
        .DEPTH       (DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic trec_t in_rec(int k);
        in_rec = '{pc: bus.in_pc_i[k], target: bus.in_target_i[k],
                   is_cond: bus.in_is_cond_i[k], taken: bus.in_taken_i[k],
                   is_call: bus.in_is_call_i[k], is_ret: bus.in_is_ret_i[k]};
    endfunction

    function automatic trec_t out_rec();
        out_rec = '{pc: bus.update_pc_o, target: bus.update_target_o,
                    is_cond: bus.update_is_cond_o, taken: bus.update_taken_o,
                    is_call: bus.update_is_call_o, is_ret: bus.update_is_ret_o};
    endfunction

    function automatic bit exp_ready();
        return (DEPTH - mq.size()) >= W;
    endfunction

    function automatic void exp_out(output bit v, output trec_t r);
        int lo;
        v  = 1'b0;
        r  = '0;
        lo = -1;
        for (int k = W - 1; k >= 0; k--) if (bus.in_valid_i[k]) lo = k;
        if (mq.size() != 0) begin
            v = 1'b1;
            r = mq[0];
        end else if (Byp && exp_ready() && lo >= 0) begin
            v = 1'b1;
            r = in_rec(lo);
        end
    endfunction

    // Reference model: FIFO of records in program order, updated at each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            bit acc, skip;
            acc  = exp_ready() && (bus.in_valid_i != '0);
            skip = 1'b0;
            if (mq.size() != 0) void'(mq.pop_front());
            else skip = Byp && acc;
            if (acc) begin
                for (int k = 0; k < W; k++) begin
                    if (bus.in_valid_i[k]) begin
                        if (skip) skip = 1'b0;
                        else mq.push_back(in_rec(k));
                    end
                end
            end
        end
    end

    task automatic drive(input logic [W-1:0] v, input logic [31:0] base, input bit rnd);
        @(negedge clk);
        bus.in_valid_i = v;
        for (int k = 0; k < W; k++) begin
            bus.in_pc_i[k]      = base + 32'(4 * k);
            bus.in_target_i[k]  = rnd ? $urandom : base + 32'h1000 + 32'(4 * k);
            bus.in_is_cond_i[k] = rnd ? 1'($urandom) : 1'b0;
            bus.in_taken_i[k]   = rnd ? 1'($urandom) : 1'b0;
            bus.in_is_call_i[k] = rnd ? 1'($urandom) : 1'b0;
            bus.in_is_ret_i[k]  = rnd ? 1'($urandom) : 1'b0;
        end
    endtask

    task automatic drain_quiet();
        int n = 0;
        while (mq.size() != 0 && n < 30) begin
            drive('0, 32'h0, 1'b0);
            n++;
        end
        drive('0, 32'h0, 1'b0);
        total++;
        if (mq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout left=%0d required=0", mq.size());
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (bus.update_valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b exp=0", bus.update_valid_o);
        end
        total++;
        if (bus.count_o !== '0) begin
            bad++; $display("FAIL reset_count got=%0d exp=0", bus.count_o);
        end
        total++;
        if (bus.in_ready_o !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready_o);
        end
        total++;
        if (bus.update_pc_o !== '0) begin
            bad++; $display("FAIL reset_pc got=%h exp=0", bus.update_pc_o);
        end
    endtask

`ifndef BP_UPDATE_BYPASS_EN
    task automatic test_sparse();
        drive(4'b1010, 32'h100, 1'b0);
        bus.in_is_cond_i[1] = 1'b1;
        bus.in_taken_i[1]   = 1'b1;
        bus.in_is_call_i[3] = 1'b1;
        #1;
        total++;
        if (bus.update_valid_o !== 1'b0) begin
            bad++; $display("FAIL sparse_t0_valid got=%b exp=0", bus.update_valid_o);
        end
        drive('0, 32'h0, 1'b0);
        #1;
        total++;
        if (bus.update_valid_o !== 1'b1 || bus.update_pc_o !== 32'h104) begin
            bad++;
            $display("FAIL sparse_t1 got v=%b pc=%h exp v=1 pc=104",
                     bus.update_valid_o, bus.update_pc_o);
        end
        total++;
        if (bus.update_is_cond_o !== 1'b1 || bus.update_taken_o !== 1'b1 ||
            bus.update_is_call_o !== 1'b0 || bus.count_o !== 4'd2) begin
            bad++;
            $display("FAIL sparse_t1_flags got c=%b t=%b call=%b cnt=%0d exp 1 1 0 2",
                     bus.update_is_cond_o, bus.update_taken_o, bus.update_is_call_o,
                     bus.count_o);
        end
        drive('0, 32'h0, 1'b0);
        #1;
        total++;
        if (bus.update_pc_o !== 32'h10C || bus.update_is_call_o !== 1'b1 ||
            bus.update_is_cond_o !== 1'b0 || bus.update_target_o !== 32'h110C) begin
            bad++;
            $display("FAIL sparse_t2 got pc=%h call=%b cond=%b tgt=%h exp 10c 1 0 110c",
                     bus.update_pc_o, bus.update_is_call_o, bus.update_is_cond_o,
                     bus.update_target_o);
        end
        drive('0, 32'h0, 1'b0);
        #1;
        total++;
        if (bus.update_valid_o !== 1'b0 || bus.update_pc_o !== '0 || bus.count_o !== '0) begin
            bad++;
            $display("FAIL sparse_t3 got v=%b pc=%h cnt=%0d exp 0 0 0",
                     bus.update_valid_o, bus.update_pc_o, bus.count_o);
        end
    endtask

    task automatic test_backpressure();
        int    exp_cnt[6] = '{0, 4, 7, 6, 5, 4};
        bit    exp_rdy[6] = '{1, 1, 0, 0, 0, 1};
        bit    ev;
        trec_t er;
        int    n;
        for (int c = 0; c < 6; c++) begin
            drive(4'b1111, 32'h300 + 32'(c * 'h100), 1'b0);
            #1;
            total++;
            if (bus.count_o !== CNT_W'(exp_cnt[c]) || bus.in_ready_o !== exp_rdy[c]) begin
                bad++;
                $display("FAIL bp_cycle%0d got cnt=%0d rdy=%b exp cnt=%0d rdy=%b", c,
                         bus.count_o, bus.in_ready_o, exp_cnt[c], exp_rdy[c]);
            end
        end
        total++;
        if (bus.update_pc_o !== 32'h400) begin
            bad++; $display("FAIL bp_order got pc=%h exp=400", bus.update_pc_o);
        end
        n = 0;
        while (mq.size() != 0 && n < 30) begin
            drive('0, 32'h0, 1'b0);
            #1;
            exp_out(ev, er);
            total++;
            if (bus.update_valid_o !== ev || out_rec() !== er) begin
                bad++;
                $display("FAIL bp_drain got v=%b rec=%h exp v=%b rec=%h",
                         bus.update_valid_o, out_rec(), ev, er);
            end
            n++;
        end
        drain_quiet();
    endtask
`endif

`ifdef BP_UPDATE_BYPASS_EN
    task automatic test_bypass();
        drive(4'b0101, 32'h200, 1'b0);
        #1;
        total++;
        if (bus.update_valid_o !== 1'b1 || bus.update_pc_o !== 32'h200 || bus.count_o !== '0)
        begin
            bad++;
            $display("FAIL byp_t0 got v=%b pc=%h cnt=%0d exp 1 200 0",
                     bus.update_valid_o, bus.update_pc_o, bus.count_o);
        end
        drive('0, 32'h0, 1'b0);
        #1;
        total++;
        if (bus.update_valid_o !== 1'b1 || bus.update_pc_o !== 32'h208 || bus.count_o !== 4'd1)
        begin
            bad++;
            $display("FAIL byp_t1 got v=%b pc=%h cnt=%0d exp 1 208 1",
                     bus.update_valid_o, bus.update_pc_o, bus.count_o);
        end
        drive('0, 32'h0, 1'b0);
        #1;
        total++;
        if (bus.update_valid_o !== 1'b0 || bus.count_o !== '0) begin
            bad++;
            $display("FAIL byp_t2 got v=%b cnt=%0d exp 0 0", bus.update_valid_o, bus.count_o);
        end
    endtask
`endif

    task automatic test_wrap_order();
        logic [31:0] got_pc[$];
        bit          got_call[$];
        bit          got_ret[$];
        int          s;
        for (int k = 0; k < 20; k++) begin
            s = $urandom_range(0, W - 1);
            drive(W'(1) << s, 32'h1000 + 32'(4 * k) - 32'(4 * s), 1'b0);
            bus.in_is_call_i[s] = (k % 2 == 0);
            bus.in_is_ret_i[s]  = (k % 2 == 1);
            #1;
            if (bus.update_valid_o === 1'b1) begin
                got_pc.push_back(bus.update_pc_o);
                got_call.push_back(bus.update_is_call_o);
                got_ret.push_back(bus.update_is_ret_o);
            end
        end
        for (int c = 0; c < 10; c++) begin
            drive('0, 32'h0, 1'b0);
            #1;
            if (bus.update_valid_o === 1'b1) begin
                got_pc.push_back(bus.update_pc_o);
                got_call.push_back(bus.update_is_call_o);
                got_ret.push_back(bus.update_is_ret_o);
            end
        end
        total++;
        if (got_pc.size() != 20) begin
            bad++; $display("FAIL wrap_count got=%0d exp=20", got_pc.size());
        end
        for (int k = 0; k < 20 && k < got_pc.size(); k++) begin
            total++;
            if (got_pc[k] !== 32'h1000 + 32'(4 * k) || got_call[k] !== (k % 2 == 0) ||
                got_ret[k] !== (k % 2 == 1)) begin
                bad++;
                $display("FAIL wrap_rec%0d got pc=%h call=%b ret=%b exp pc=%h call=%b", k,
                         got_pc[k], got_call[k], got_ret[k], 32'h1000 + 32'(4 * k),
                         (k % 2 == 0));
            end
        end
    endtask

    task automatic test_random();
        bit          ev;
        trec_t       er;
        logic [W-1:0] v;
        for (int c = 0; c < 150; c++) begin
            v = ($urandom_range(0, 9) < 3) ? '0 : W'($urandom);
            drive(v, $urandom, 1'b1);
            #1;
            exp_out(ev, er);
            total++;
            if (bus.update_valid_o !== ev) begin
                bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, bus.update_valid_o, ev);
            end
            total++;
            if (out_rec() !== er) begin
                bad++; $display("FAIL rnd_rec cyc=%0d got=%h exp=%h", c, out_rec(), er);
            end
            total++;
            if (bus.count_o !== CNT_W'(mq.size())) begin
                bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, bus.count_o,
                                mq.size());
            end
            total++;
            if (bus.in_ready_o !== exp_ready()) begin
                bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bus.in_ready_o,
                                exp_ready());
            end
        end
        drain_quiet();
    endtask

    task automatic test_reset_mid();
        drive(4'b1111, 32'h500, 1'b0);
`ifdef BP_UPDATE_BYPASS_EN
        drive(4'b0111, 32'h600, 1'b0);
`else
        drive(4'b0011, 32'h600, 1'b0);
`endif
        drive('0, 32'h0, 1'b0);
        #1;
        total++;
        if (bus.count_o !== 4'd5 || bus.update_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_fill got cnt=%0d v=%b exp cnt=5 v=1",
                     bus.count_o, bus.update_valid_o);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.update_valid_o !== 1'b0 || bus.count_o !== '0 || bus.in_ready_o !== 1'b1 ||
            bus.update_pc_o !== '0) begin
            bad++;
            $display("FAIL rstmid_async got v=%b cnt=%0d rdy=%b pc=%h exp 0 0 1 0",
                     bus.update_valid_o, bus.count_o, bus.in_ready_o, bus.update_pc_o);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive('0, 32'h0, 1'b0);
            #1;
            total++;
            if (bus.update_valid_o !== 1'b0 || bus.count_o !== '0) begin
                bad++;
                $display("FAIL rstmid_stale%0d got v=%b cnt=%0d exp 0 0", c,
                         bus.update_valid_o, bus.count_o);
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.in_valid_i   = '0;
        bus.in_pc_i      = '0;
        bus.in_target_i  = '0;
        bus.in_is_cond_i = '0;
        bus.in_taken_i   = '0;
        bus.in_is_call_i = '0;
        bus.in_is_ret_i  = '0;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
`ifdef BP_UPDATE_BYPASS_EN
        test_bypass();
`else
        test_sparse();
        test_backpressure();
`endif
        test_wrap_order();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
